// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared opcode, select-bit and state encodings for the ALU
//             front-end sequencer and its opcode decoder.
//  Revision : 1.0
// ============================================================================
package alu_pkg;

  // Opcode encodings
  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_NOT = 3'd3;
  localparam logic [2:0] OP_ADD = 3'd4;
  localparam logic [2:0] OP_SUB = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_ILL = 3'd7;

  // Bit positions inside the one-hot multiplexer select
  localparam int SEL_AND = 0;
  localparam int SEL_OR  = 1;
  localparam int SEL_XOR = 2;
  localparam int SEL_NOT = 3;
  localparam int SEL_ADD = 4;
  localparam int SEL_MUL = 5;

  localparam int SEL_W = 6;

  // Sequencer state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// ============================================================================
//  Module   : alu_op_decode
//  Purpose  : Combinational opcode decode into one-hot mux select, add/sub
//             control, multiply flag and illegal-opcode flag.
//  Revision : 1.0
// ============================================================================
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [2:0]       opcode,
  output logic [SEL_W-1:0] sel_next,
  output logic             sub_next,
  output logic             is_mul,
  output logic             illegal
);

  // Map each opcode to exactly one select bit; the illegal opcode selects nothing
  always_comb begin
    sel_next = '0;
    sub_next = 1'b0;
    is_mul   = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OP_AND:  sel_next[SEL_AND] = 1'b1;
      OP_OR:   sel_next[SEL_OR]  = 1'b1;
      OP_XOR:  sel_next[SEL_XOR] = 1'b1;
      OP_NOT:  sel_next[SEL_NOT] = 1'b1;
      OP_ADD:  sel_next[SEL_ADD] = 1'b1;
      OP_SUB: begin
        sel_next[SEL_ADD] = 1'b1;
        sub_next          = 1'b1;
      end
      OP_MUL: begin
        sel_next[SEL_MUL] = 1'b1;
        is_mul            = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule : alu_op_decode
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_op_sequencer
//  Purpose  : Accepts an ALU request, drives the one-hot result-mux select for
//             the operation latency, captures the mux output and returns it
//             over a valid/ready result handshake.
//  Revision : 1.0
// ============================================================================
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int K        = 7,
  parameter int MULT_LAT = 3
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       opcode,
  input  logic [K-1:0]     a_in,
  input  logic [K-1:0]     b_in,
  output logic [K-1:0]     a_out,
  output logic [K-1:0]     b_out,
  output logic             sub,
  output logic [SEL_W-1:0] sel,
  input  logic [K-1:0]     mux_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [K-1:0]     res_data,
  output logic             res_err
);

  // Counter preload: a value of 0 at the first MUL cycle means one MUL cycle
  localparam logic [3:0] MUL_LOAD = 4'(MULT_LAT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       counter;
  logic [SEL_W-1:0] dec_sel;
  logic             dec_sub;
  logic             dec_is_mul;
  logic             dec_illegal;
  logic             accept;
  logic             capture;

  alu_op_decode u_decode (
    .opcode   (opcode),
    .sel_next (dec_sel),
    .sub_next (dec_sub),
    .is_mul   (dec_is_mul),
    .illegal  (dec_illegal)
  );

  assign op_ready = (state == ST_IDLE);
  assign accept   = op_valid && op_ready;
  // The mux output is sampled on the last cycle the select is held
  assign capture  = (state == ST_EXEC) || ((state == ST_MUL) && (counter == 4'd0));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (dec_illegal)     state_nxt = ST_DONE;
          else if (dec_is_mul) state_nxt = ST_MUL;
          else                 state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: state_nxt = ST_DONE;
      ST_MUL:  if (counter == 4'd0) state_nxt = ST_DONE;
      ST_DONE: if (res_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand, select, counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out     <= '0;
      b_out     <= '0;
      sub       <= 1'b0;
      sel       <= '0;
      counter   <= 4'd0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_err   <= 1'b0;
    end else begin
      if (accept) begin
        a_out   <= a_in;
        b_out   <= b_in;
        sub     <= dec_sub;
        sel     <= dec_sel;
        counter <= dec_is_mul ? MUL_LOAD : 4'd0;
        if (dec_illegal) begin
          res_data  <= '0;
          res_err   <= 1'b1;
          res_valid <= 1'b1;
        end
      end
      if ((state == ST_MUL) && (counter != 4'd0)) begin
        counter <= counter - 4'd1;
      end
      if (capture) begin
        res_data  <= mux_in;
        res_err   <= 1'b0;
        sel       <= '0;
        res_valid <= 1'b1;
      end
      if ((state == ST_DONE) && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule : alu_op_sequencer
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_op_sequencer
//  Purpose  : Directed self-checking bench for alu_op_sequencer, with the ALU
//             function units and output mux modelled around the sequencer.
//  Revision : 1.0
// ============================================================================
module tb_alu_op_sequencer;

  localparam int K        = 7;
  localparam int MULT_LAT = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         op_valid;
  logic         op_ready;
  logic [2:0]   opcode;
  logic [K-1:0] a_in;
  logic [K-1:0] b_in;
  logic [K-1:0] a_out;
  logic [K-1:0] b_out;
  logic         sub;
  logic [5:0]   sel;
  logic [K-1:0] mux_in;
  logic         res_valid;
  logic         res_ready;
  logic [K-1:0] res_data;
  logic         res_err;

  int checks = 0;
  int errors = 0;

  alu_op_sequencer #(.K(K), .MULT_LAT(MULT_LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .opcode    (opcode),
    .a_in      (a_in),
    .b_in      (b_in),
    .a_out     (a_out),
    .b_out     (b_out),
    .sub       (sub),
    .sel       (sel),
    .mux_in    (mux_in),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_err   (res_err)
  );

  always #5 clk = ~clk;

  // Function units and one-hot output multiplexer
  always_comb begin
    mux_in = '0;
    if (sel[0]) mux_in = mux_in | (a_out & b_out);
    if (sel[1]) mux_in = mux_in | (a_out | b_out);
    if (sel[2]) mux_in = mux_in | (a_out ^ b_out);
    if (sel[3]) mux_in = mux_in | (~a_out);
    if (sel[4]) mux_in = mux_in | (sub ? (a_out - b_out) : (a_out + b_out));
    if (sel[5]) mux_in = mux_in | (a_out * b_out);
  end

  // Select must always be zero or one-hot
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ((sel & (sel - 6'd1)) != 6'd0) begin
        errors++;
        $display("FAIL sel_onehot: sel=%b required zero or one-hot", sel);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold it for the accept edge; returns just after it
  task automatic issue(input logic [2:0] op, input logic [K-1:0] a, input logic [K-1:0] b);
    op_valid = 1'b1;
    opcode   = op;
    a_in     = a;
    b_in     = b;
    step();
    op_valid = 1'b0;
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || op_ready !== 1'b1) begin
      errors++;
      $display("FAIL handshake: res_valid=%b op_ready=%b required 0 1", res_valid, op_ready);
    end
  endtask

  // Single-cycle op: checks select one edge after accept, result one later
  task automatic run_single(input string name, input logic [2:0] op,
                            input logic [K-1:0] a, input logic [K-1:0] b,
                            input logic [5:0] exp_sel, input logic exp_sub,
                            input logic [K-1:0] exp_res);
    issue(op, a, b);
    checks++;
    if (sel !== exp_sel || sub !== exp_sub || res_valid !== 1'b0 || op_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_exec: sel=%b sub=%b res_valid=%b op_ready=%b required %b %b 0 0",
               name, sel, sub, res_valid, op_ready, exp_sel, exp_sub);
    end
    step();
    checks++;
    if (res_valid !== 1'b1 || res_data !== exp_res || res_err !== 1'b0 || sel !== 6'd0) begin
      errors++;
      $display("FAIL %s_result: valid=%b data=%h err=%b sel=%b required 1 %h 0 000000",
               name, res_valid, res_data, res_err, sel, exp_res);
    end
    release_result();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    op_valid  = 1'b0;
    opcode    = 3'd0;
    a_in      = '0;
    b_in      = '0;
    res_ready = 1'b0;
    #2;
    checks++;
    if (op_ready !== 1'b1 || sel !== 6'd0 || res_valid !== 1'b0 || res_data !== 7'd0) begin
      errors++;
      $display("FAIL reset_initial: op_ready=%b sel=%b res_valid=%b res_data=%h required 1 0 0 0",
               op_ready, sel, res_valid, res_data);
    end
    step();
    rst_n = 1'b1;
    step();
    // Abort a multiply mid-flight
    issue(3'd6, 7'd5, 7'd6);
    step();
    checks++;
    if (sel !== 6'b100000) begin
      errors++;
      $display("FAIL reset_pre_mul: sel=%b required 100000", sel);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (op_ready !== 1'b1 || sel !== 6'd0 || res_valid !== 1'b0 || res_data !== 7'd0) begin
      errors++;
      $display("FAIL reset_async: op_ready=%b sel=%b res_valid=%b res_data=%h required 1 0 0 0",
               op_ready, sel, res_valid, res_data);
    end
    step();
    rst_n = 1'b1;
    step();
    step();
    step();
    checks++;
    if (res_valid !== 1'b0 || op_ready !== 1'b1 || sel !== 6'd0) begin
      errors++;
      $display("FAIL reset_abort: res_valid=%b op_ready=%b sel=%b required 0 1 0",
               res_valid, op_ready, sel);
    end
  endtask

  task automatic test_and();
    run_single("and", 3'd0, 7'h55, 7'h0F, 6'b000001, 1'b0, 7'h05);
  endtask

  task automatic test_logic_ops();
    run_single("or",  3'd1, 7'h55, 7'h0F, 6'b000010, 1'b0, 7'h5F);
    run_single("xor", 3'd2, 7'h55, 7'h0F, 6'b000100, 1'b0, 7'h5A);
    run_single("not", 3'd3, 7'h55, 7'h0F, 6'b001000, 1'b0, 7'h2A);
  endtask

  task automatic test_addsub();
    run_single("sub", 3'd5, 7'd10, 7'd3, 6'b010000, 1'b1, 7'd7);
    run_single("add", 3'd4, 7'd100, 7'd50, 6'b010000, 1'b0, 7'd22);
  endtask

  task automatic test_mul();
    int n = 0;
    int sel_cycles = 0;
    int ready_seen = 0;
    issue(3'd6, 7'd5, 7'd6);
    while (res_valid !== 1'b1 && n < 20) begin
      if (sel === 6'b100000) sel_cycles++;
      if (op_ready !== 1'b0) ready_seen++;
      step();
      n++;
    end
    checks++;
    if (n != MULT_LAT || sel_cycles != MULT_LAT) begin
      errors++;
      $display("FAIL mul_timing: edges_after_accept=%0d sel_cycles=%0d required %0d %0d",
               n, sel_cycles, MULT_LAT, MULT_LAT);
    end
    checks++;
    if (ready_seen != 0 || op_ready !== 1'b0) begin
      errors++;
      $display("FAIL mul_op_ready: ready_cycles=%0d op_ready=%b required 0 0", ready_seen, op_ready);
    end
    checks++;
    if (res_data !== 7'd30 || res_err !== 1'b0 || sel !== 6'd0) begin
      errors++;
      $display("FAIL mul_result: data=%0d err=%b sel=%b required 30 0 000000", res_data, res_err, sel);
    end
    release_result();
  endtask

  task automatic test_illegal();
    issue(3'd7, 7'h7F, 7'h7F);
    checks++;
    if (res_valid !== 1'b1 || res_err !== 1'b1 || res_data !== 7'd0 || sel !== 6'd0) begin
      errors++;
      $display("FAIL illegal: valid=%b err=%b data=%h sel=%b required 1 1 0 000000",
               res_valid, res_err, res_data, sel);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    issue(3'd2, 7'h33, 7'h0F);
    step();
    // New request waits while the result is backpressured
    op_valid = 1'b1;
    opcode   = 3'd0;
    a_in     = 7'h7E;
    b_in     = 7'h3C;
    for (int i = 0; i < 5; i++) begin
      if (res_valid !== 1'b1 || res_data !== 7'h3C || op_ready !== 1'b0 || a_out !== 7'h33) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL backpressure: unstable_cycles=%0d data=%h op_ready=%b required 0 3c 0",
               bad, res_data, op_ready);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    checks++;
    if (op_ready !== 1'b1 || res_valid !== 1'b0 || a_out !== 7'h33) begin
      errors++;
      $display("FAIL bp_release: op_ready=%b res_valid=%b a_out=%h required 1 0 33",
               op_ready, res_valid, a_out);
    end
    step();
    op_valid = 1'b0;
    checks++;
    if (a_out !== 7'h7E || b_out !== 7'h3C || sel !== 6'b000001 || op_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_next_accept: a_out=%h b_out=%h sel=%b op_ready=%b required 7e 3c 000001 0",
               a_out, b_out, sel, op_ready);
    end
    step();
    checks++;
    if (res_valid !== 1'b1 || res_data !== 7'h3C) begin
      errors++;
      $display("FAIL bp_next_result: valid=%b data=%h required 1 3c", res_valid, res_data);
    end
    release_result();
  endtask

  initial begin
    test_reset();
    test_and();
    test_logic_ops();
    test_addsub();
    test_mul();
    test_illegal();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_alu_op_sequencer
`default_nettype wire

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Front-end controller for the ALU result path; it is the producer of the 6-bit one-hot select consumed by the ALU output multiplexer.
- Accepts an opcode and two K-bit operands over a valid/ready handshake and decodes the opcode into the one-hot select plus the add/subtract control.
- Holds the select for the operation's latency: 1 cycle, or MULT_LAT cycles for multiply.
- Captures the multiplexer output and returns it over a second valid/ready handshake.

Parameters:
K, 7, operand/result width; matches the output multiplexer width.
MULT_LAT, 3, multiply latency in cycles; legal range 1..15.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
op_valid  in  1  request valid
op_ready  out  1  request ready
opcode  in  3  0 AND, 1 OR, 2 XOR, 3 NOT, 4 ADD, 5 SUB, 6 MUL, 7 illegal
a_in  in  K  operand A
b_in  in  K  operand B
a_out  out  K  registered operand A to the function units
b_out  out  K  registered operand B to the function units
sub  out  1  add/sub unit control: 1 = subtract
sel  out  6  one-hot mux select: bit0 AND, 1 OR, 2 XOR, 3 NOT, 4 addSub, 5 mult
mux_in  in  K  output-multiplexer result, fed back
res_valid  out  1  result valid
res_ready  in  1  result ready
res_data  out  K  captured result
res_err  out  1  result belongs to an illegal opcode

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, op_ready = 1, counter = 0.
  - All other outputs and internal registers = 0.
  - Reset mid-operation aborts the operation; no result is produced.
- All outputs are registered, except op_ready, which is decoded from state.
- States: IDLE, EXEC, MUL, DONE.
- IDLE:
  - op_ready = 1 and sel = 0.
  - On op_valid && op_ready: latch a_in→a_out, b_in→b_out, set sub = (opcode==5), and store the opcode.
  - Next state for opcodes 0–5: EXEC.
  - Next state for opcode 6: MUL, with counter = MULT_LAT-1.
  - Next state for opcode 7: DONE, with res_data = 0, res_err = 1, sel stays 0.
  - sel is loaded at the same edge, so it is valid in the first EXEC/MUL cycle.
- EXEC:
  - sel has exactly one bit set: opcodes 0–3 → bits 0–3, opcodes 4 and 5 → bit 4.
  - At the end of the cycle: res_data ← mux_in, res_err ← 0, sel ← 0, go to DONE.
- MUL:
  - sel = 6'b100000 for exactly MULT_LAT consecutive cycles.
  - Counter decrements each cycle.
  - At the edge where counter == 0: capture mux_in, clear sel, go to DONE.
  - MULT_LAT = 1 is timed identically to EXEC.
- DONE:
  - res_valid = 1; res_data and res_err are held stable.
  - a_out, b_out and sub are held stable.
  - On res_ready: res_valid ← 0, go to IDLE.
  - res_ready asserted outside DONE is ignored.
- op_ready = 0 in every state except IDLE; no overlap of requests. op_valid while not ready is ignored; the source must hold it.
- Latency, request-accept edge N to res_valid high:
  - 2 edges for opcodes 0–5;
  - MULT_LAT+1 edges for MUL;
  - 1 edge for illegal.
- Best-case throughput: one operation per 3 cycles, with res_ready tied high.
- Invariant: sel is always zero or one-hot; never more than one bit set. sel is 0 in IDLE and DONE.
- No arithmetic is performed here; widths pass through unchanged. The counter is 4 bits.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams OP_AND..OP_MUL, OP_ILL;
  - select-bit index constants SEL_AND..SEL_MUL;
  - state encoding constants.
- Optional sub-module alu_op_decode: combinational opcode→{sel_next, sub_next, is_mul, illegal}. It is reused by any later pipelined variant.
- The FSM and counter stay in the top module.

Test Plan:
1. Reset: hold rst_n low mid-MUL, release → op_ready=1, sel=0, res_valid=0, res_data=0 at once, without waiting for a clock edge.
2. AND, K=7: a=7'h55, b=7'h0F, with mux_in modelled by the real output mux and function units → sel=6'b000001 for one cycle, then res_data=7'h05 and res_valid=1 two edges after accept.
3. SUB: a=10, b=3 → sub=1, sel=6'b010000 for one cycle, res_data=7 and res_err=0.
4. MUL with MULT_LAT=3: a=5, b=6 → sel=6'b100000 for exactly 3 cycles, res_data=30 at edge 4; op_ready low throughout.
5. Illegal opcode 7 → sel never nonzero; res_valid one edge after accept; res_err=1, res_data=0.
6. Backpressure: res_ready low for 5 cycles in DONE while op_valid is high → res_data stable, op_ready=0. After the res_ready handshake → IDLE, next request accepted; checker asserts sel is always zero or one-hot.
